// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register between the memory stage and the
// register file. It captures the memory-stage result, extends load data by
// type and byte offset, qualifies the register file write, counts retired
// instructions and drives the debug writeback trace.
//
// Ports:
//   clk, rst (async active-low)     clock and reset
//   stall, flush                    hold registers / insert a bubble
//   m_valid, m_reg_write,           memory-stage instruction qualifiers
//   m_mem_to_reg, m_load_type
//   m_addr, m_rdata, m_wa, m_pc     memory-stage payload
//   we3, wa3, wd3                   register file write port
//   wb_misalign                     captured load was misaligned
//   instret                         retired-instruction counter
//   debug_wb_*                      writeback trace
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_reg_write,
  input  logic        m_mem_to_reg,
  input  logic [2:0]  m_load_type,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_pc,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        wb_misalign,
  output logic [31:0] instret,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100
  } load_e;

  logic        we_q, we_d;
  logic [4:0]  wa_q;
  logic [31:0] wd_q, wd_d;
  logic        mis_q, mis_d;
  logic [31:0] instret_q;
  logic [31:0] pc_q;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = m_rdata[7:0];
    case (m_addr[1:0])
      2'd0:    byte_v = m_rdata[7:0];
      2'd1:    byte_v = m_rdata[15:8];
      2'd2:    byte_v = m_rdata[23:16];
      default: byte_v = m_rdata[31:24];
    endcase
    half_v = m_addr[1] ? m_rdata[31:16] : m_rdata[15:0];
  end

  // Reserved load types fall into the default arm and behave as LW,
  // including the word alignment check.
  always_comb begin
    wd_d  = m_addr;
    mis_d = 1'b0;
    if (m_mem_to_reg) begin
      case (load_e'(m_load_type))
        LD_LB:  wd_d = {{24{byte_v[7]}}, byte_v};
        LD_LBU: wd_d = {24'd0, byte_v};
        LD_LH: begin
          wd_d  = {{16{half_v[15]}}, half_v};
          mis_d = m_addr[0];
        end
        LD_LHU: begin
          wd_d  = {16'd0, half_v};
          mis_d = m_addr[0];
        end
        default: begin
          wd_d  = m_rdata;
          mis_d = (m_addr[1:0] != 2'd0);
        end
      endcase
    end
    we_d = m_valid & m_reg_write & (m_wa != 5'd0) & ~mis_d;
  end

  // Flush only clears the write qualifiers; address, data and PC keep their
  // previous values so a bubble never disturbs the trace payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      mis_q     <= 1'b0;
      instret_q <= '0;
      pc_q      <= PC_RESET;
    end else if (flush) begin
      we_q  <= 1'b0;
      mis_q <= 1'b0;
    end else if (!stall) begin
      we_q      <= we_d;
      wa_q      <= m_wa;
      wd_q      <= wd_d;
      mis_q     <= mis_d;
      pc_q      <= m_pc;
      instret_q <= instret_q + {31'd0, m_valid};
    end
  end

  assign we3               = we_q;
  assign wa3               = wa_q;
  assign wd3               = wd_q;
  assign wb_misalign       = mis_q;
  assign instret           = instret_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{we_q}};
  assign debug_wb_rf_wnum  = wa_q;
  assign debug_wb_rf_wdata = wd_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam logic [31:0] PC_RST = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        m_valid, m_reg_write, m_mem_to_reg;
  logic [2:0]  m_load_type;
  logic [31:0] m_addr, m_rdata, m_pc;
  logic [4:0]  m_wa;
  logic        we3, wb_misalign;
  logic [4:0]  wa3, debug_wb_rf_wnum;
  logic [31:0] wd3, instret, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  logic        e_we, e_mis;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_inst, e_pc;

  always #5 clk = ~clk;

  wb_stage #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
    .m_load_type(m_load_type), .m_addr(m_addr), .m_rdata(m_rdata),
    .m_wa(m_wa), .m_pc(m_pc),
    .we3(we3), .wa3(wa3), .wd3(wd3), .wb_misalign(wb_misalign),
    .instret(instret), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we3"}, {31'd0, we3}, {31'd0, e_we});
    chk({tag, ".wa3"}, {27'd0, wa3}, {27'd0, e_wa});
    chk({tag, ".wd3"}, wd3, e_wd);
    chk({tag, ".mis"}, {31'd0, wb_misalign}, {31'd0, e_mis});
    chk({tag, ".instret"}, instret, e_inst);
    chk({tag, ".pc"}, debug_wb_pc, e_pc);
    chk({tag, ".dwen"}, {28'd0, debug_wb_rf_wen}, e_we ? 32'hF : 32'h0);
    chk({tag, ".dwnum"}, {27'd0, debug_wb_rf_wnum}, {27'd0, e_wa});
    chk({tag, ".dwdata"}, debug_wb_rf_wdata, e_wd);
  endtask

  function automatic void model_reset();
    e_we = 1'b0; e_mis = 1'b0; e_wa = '0; e_wd = '0; e_inst = '0; e_pc = PC_RST;
  endfunction

  // Behavioural writeback rules computed with plain arithmetic.
  function automatic void model_edge();
    int unsigned k, t;
    logic [31:0] b, h, d;
    logic mis;
    if (flush) begin
      e_we = 1'b0;
      e_mis = 1'b0;
    end else if (!stall) begin
      k = m_addr % 4;
      t = m_load_type;
      d = m_addr;
      mis = 1'b0;
      if (m_mem_to_reg) begin
        b = (m_rdata >> (8 * k)) & 32'hFF;
        h = (m_rdata >> (16 * (k / 2))) & 32'hFFFF;
        if (t == 1)      d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        else if (t == 2) d = b;
        else if (t == 3) d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        else if (t == 4) d = h;
        else             d = m_rdata;
        if (t == 3 || t == 4) mis = (k % 2) == 1;
        else if (t != 1 && t != 2) mis = (k != 0);
      end
      e_we = m_valid && m_reg_write && (m_wa != 0) && !mis;
      e_mis = mis;
      e_wa = m_wa;
      e_wd = d;
      e_pc = m_pc;
      e_inst = e_inst + (m_valid ? 32'd1 : 32'd0);
    end
  endfunction

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [31:0] addr, input logic [31:0] rd, input logic [4:0] wa,
                       input logic [31:0] pc);
    m_valid = v; m_reg_write = rw; m_mem_to_reg = m2r; m_load_type = lt;
    m_addr = addr; m_rdata = rd; m_wa = wa; m_pc = pc;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    #2;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 3'd0, '0, '0, '0, '0);
    model_reset();

    // reset then idle
    repeat (3) cycle();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    check_all("idle");

    // ALU write
    drive(1, 1, 0, 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 5'd8, 32'hBFC0_0100);
    cycle();
    check_all("alu");
    chk("alu.we3.spec", {31'd0, we3}, 32'd1);
    chk("alu.wd3.spec", wd3, 32'h1234_5678);
    chk("alu.dwen.spec", {28'd0, debug_wb_rf_wen}, 32'hF);
    chk("alu.inst.spec", instret, 32'd1);

    // loads
    drive(1, 1, 1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 5'd9, 32'hBFC0_0104);
    cycle(); check_all("lb3"); chk("lb3.spec", wd3, 32'hFFFF_FF80);
    drive(1, 1, 1, 3'd2, 32'h0000_1001, 32'h80FF_7F01, 5'd10, 32'hBFC0_0108);
    cycle(); check_all("lbu1"); chk("lbu1.spec", wd3, 32'h0000_007F);
    drive(1, 1, 1, 3'd3, 32'h0000_1002, 32'h80FF_7F01, 5'd11, 32'hBFC0_010C);
    cycle(); check_all("lh2"); chk("lh2.spec", wd3, 32'hFFFF_80FF);
    drive(1, 1, 1, 3'd4, 32'h0000_1000, 32'h80FF_7F01, 5'd12, 32'hBFC0_0110);
    cycle(); check_all("lhu0"); chk("lhu0.spec", wd3, 32'h0000_7F01);

    // misaligned and r0
    drive(1, 1, 1, 3'd0, 32'h1000_0002, 32'h1111_2222, 5'd13, 32'hBFC0_0114);
    cycle(); check_all("lw_mis");
    chk("lw_mis.we3.spec", {31'd0, we3}, 32'd0);
    chk("lw_mis.mis.spec", {31'd0, wb_misalign}, 32'd1);
    chk("lw_mis.inst.spec", instret, 32'd6);
    drive(1, 1, 1, 3'd3, 32'h1000_0001, 32'h1111_2222, 5'd14, 32'hBFC0_0118);
    cycle(); check_all("lh_mis");
    drive(1, 1, 0, 3'd0, 32'h5555_AAAA, 32'h0, 5'd0, 32'hBFC0_011C);
    cycle(); check_all("r0");
    chk("r0.we3.spec", {31'd0, we3}, 32'd0);

    // stall for two cycles with changing inputs
    stall = 1'b1;
    drive(1, 1, 0, 3'd0, 32'hCAFE_0001, 32'h0, 5'd3, 32'hBFC0_0200);
    cycle(); check_all("stall1");
    drive(1, 1, 0, 3'd0, 32'hCAFE_0002, 32'h0, 5'd4, 32'hBFC0_0204);
    cycle(); check_all("stall2");
    chk("stall.inst.spec", instret, 32'd8);
    stall = 1'b0;
    cycle(); check_all("post_stall");
    stall = 1'b1; flush = 1'b1;
    cycle(); check_all("flush_stall");
    chk("flush_stall.we3.spec", {31'd0, we3}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // reset asserted mid-stall clears immediately
    stall = 1'b1;
    drive(1, 1, 0, 3'd0, 32'h7777_0000, 32'h0, 5'd5, 32'hBFC0_0300);
    #1; rst = 1'b0; #1;
    model_reset();
    check_all("rst_mid_stall");
    @(negedge clk);
    rst = 1'b1; stall = 1'b0;
    cycle(); check_all("after_rst");

    // counter wrap
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    e_inst = 32'hFFFF_FFFF;
    chk("preload", instret, 32'hFFFF_FFFF);
    drive(1, 0, 0, 3'd0, 32'h0, 32'h0, 5'd1, 32'hBFC0_0400);
    cycle(); check_all("wrap");
    chk("wrap.spec", instret, 32'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom);
      cycle();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback pipeline register for the five-stage MIPS core: it sits between the memory stage and the register file and drives the register file write port (`we3`/`wa3`/`wd3`). On each non-stalled clock it captures the memory-stage result, sign/zero-extends load data by type and byte offset, and qualifies the write. It also maintains a retired-instruction counter and drives the debug writeback trace.

## Interface
- `PC_RESET`, default 32'hBFC0_0000, value of `debug_wb_pc` after reset.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold all WB registers.
- `flush`  in  1  replace the captured instruction with a bubble.
- `m_valid`  in  1  memory-stage slot holds a real instruction.
- `m_reg_write`  in  1  instruction writes a GPR.
- `m_mem_to_reg`  in  1  result comes from load data, not ALU.
- `m_load_type`  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others reserved.
- `m_addr`  in  32  effective address or ALU result.
- `m_rdata`  in  32  data-memory read word, valid with the other `m_*` inputs.
- `m_wa`  in  5  destination register.
- `m_pc`  in  32  instruction PC.
- `we3`  out  1  register file write enable.
- `wa3`  out  5  register file write address.
- `wd3`  out  32  register file write data.
- `wb_misalign`  out  1  captured load was misaligned; write suppressed.
- `instret`  out  32  count of retired instructions.
- `debug_wb_pc`  out  32  PC of the WB instruction.
- `debug_wb_rf_wen`  out  4  all four bits equal `we3`.
- `debug_wb_rf_wnum`  out  5  equal to `wa3`.
- `debug_wb_rf_wdata`  out  32  equal to `wd3`.

## Operation
- Capture priority on each rising edge: reset > `flush` > `stall` > load.
- `flush`: the slot becomes a bubble. Valid=0, `we3`=0, `wb_misalign`=0. `wa3`, `wd3` and `debug_wb_pc` are don't-care but must hold their previous values.
- `stall` without `flush`: all registers hold. `instret` does not increment.
- Load: capture `m_*`. `wd3` is computed before the register.
  - `m_mem_to_reg`=0: `wd3` = `m_addr`.
  - LW: the word.
  - LB/LBU: byte `m_rdata[8*k+7:8*k]`, where k = `m_addr[1:0]`. LB sign-extends, LBU zero-extends.
  - LH/LHU: halfword `m_rdata[16*h+15:16*h]`, where h = `m_addr[1]`. LH sign-extends, LHU zero-extends.
  - Reserved load type: treated as LW.
- Misalignment, checked only when `m_mem_to_reg`=1:
  - LW misaligned if `m_addr[1:0]`≠0.
  - LH/LHU misaligned if `m_addr[0]`=1.
  - When misaligned: `wb_misalign`=1 and `we3`=0.
- `we3` = `m_valid` & `m_reg_write` & (`m_wa`≠0) & !misaligned.
- `instret` increments by 1 on each load edge with `m_valid`=1. This holds even if the write is suppressed. It wraps from 32'hFFFF_FFFF to 0.

## Timing
- Latency is one cycle: `m_*` sampled at edge N appears on the outputs after edge N. Outputs are registered; there are no combinational paths from inputs to outputs.
- The register file writes on the falling edge. `we3`/`wa3`/`wd3` are stable from the rising edge through the following falling edge, so decode reads in the same cycle see the written value.
- `instret` updates on the same edge as the slot it counts.
- Reset (asynchronous assert, synchronous release with `clk`) forces:
  - `we3`=0, `wa3`=0, `wd3`=0, `wb_misalign`=0, `instret`=0.
  - `debug_wb_pc`=`PC_RESET`.
  - Debug outputs mirror the reset values.
- Reset asserted mid-stall or mid-flush clears immediately. The first capture after release is a normal load.
- `flush` and `stall` asserted together: flush wins, and a bubble is written.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles → all outputs zero, `debug_wb_pc`=32'hBFC0_0000. Release with `m_valid`=0 → `we3` stays 0 and `instret` stays 0.
- ALU write: `m_valid`=1, `m_reg_write`=1, `m_mem_to_reg`=0, `m_wa`=8, `m_addr`=32'h1234_5678 → next cycle `we3`=1, `wa3`=8, `wd3`=32'h1234_5678, `debug_wb_rf_wen`=4'hF, `instret`=1.
- Loads with `m_rdata`=32'h80FF_7F01:
  - LB at offset 3 → `wd3`=32'hFFFF_FF80.
  - LBU at offset 1 → 32'h0000_007F.
  - LH at offset 2 → 32'hFFFF_80FF.
  - LHU at offset 0 → 32'h0000_7F01.
- Misaligned: LW at `m_addr`=32'h1000_0002 → `we3`=0, `wb_misalign`=1, `instret` increments. LH at 32'h...01 → same result. `m_wa`=0 with a valid ALU op → `we3`=0.
- Stall/flush: with `stall`=1 for 2 cycles while inputs change → outputs and `instret` unchanged. Assert `flush`=1 and `stall`=1 together → `we3`=0 on the next cycle.
- Counter wrap: preload `instret` to 32'hFFFF_FFFF via 2^32-1 retirements (or a force in the bench), then retire one more → `instret`=0.
